// File: rtl/pix_capture_gray.sv
// pix_capture_gray: oversampled pixel-port capture, RGB->luma, X/Y/SOF/EOL tagging.
// Rev 1.0 - initial release.
`default_nettype none

module pix_capture_gray #(
  parameter int DIM_W      = 12,
  parameter int MAX_WIDTH  = 1280,
  parameter int MAX_HEIGHT = 1024,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic             I_CORE_CLK,
  input  logic             I_RST,
  input  logic [23:0]      I_PIX_DATA,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  input  logic             I_PCLK,
  output logic [7:0]       O_GRAY,
  output logic             O_VALID,
  output logic [DIM_W-1:0] O_X,
  output logic [DIM_W-1:0] O_Y,
  output logic             O_SOF,
  output logic             O_EOL,
  output logic [DIM_W-1:0] O_LINE_WIDTH,
  output logic             O_ERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VBLANK = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_HBLANK = 2'd3;

  localparam logic [DIM_W-1:0] MAX_W_C = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] MAX_H_C = DIM_W'(MAX_HEIGHT);
  localparam logic [DIM_W-1:0] ONE_C   = DIM_W'(1);

  // Synchronizer bit layout: {pclk, vsync, hsync, de, data[23:0]}
  logic [27:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic             pclk_prev_q, pclk_prev_d;
  logic             pclk_rise;

  logic             cap_valid_q, cap_valid_d;
  logic [23:0]      cap_data_q, cap_data_d;
  logic             cap_de_q, cap_de_d;
  logic             cap_vs_q, cap_vs_d;
  logic             cap_hs_q, cap_hs_d;

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic             sof_pend_q, sof_pend_d;
  logic             err_q, err_d;

  logic [7:0]       gray_q, gray_d;
  logic             valid_q, valid_d;
  logic [DIM_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic [DIM_W-1:0] lw_q, lw_d;

  logic [15:0]      luma_sum;
  logic             emit;
  logic             unused_hsync;

  assign unused_hsync = cap_hs_q;

  always_comb begin
    sync1_d     = {I_PCLK, I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA};
    sync2_d     = sync1_q;
    pclk_prev_d = sync2_q[27];
    pclk_rise   = sync2_q[27] & ~pclk_prev_q;

    cap_valid_d = pclk_rise;
    cap_data_d  = cap_data_q;
    cap_de_d    = cap_de_q;
    cap_vs_d    = cap_vs_q;
    cap_hs_d    = cap_hs_q;
    if (pclk_rise) begin
      cap_data_d = sync2_q[23:0];
      cap_de_d   = sync2_q[24];
      cap_hs_d   = SYNC_POL ? sync2_q[25] : ~sync2_q[25];
      cap_vs_d   = SYNC_POL ? sync2_q[26] : ~sync2_q[26];
    end
  end

  always_comb begin
    luma_sum = 16'd77  * {8'd0, cap_data_q[23:16]}
             + 16'd150 * {8'd0, cap_data_q[15:8]}
             + 16'd29  * {8'd0, cap_data_q[7:0]};

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    sof_pend_d = sof_pend_q;
    err_d      = err_q;
    gray_d     = gray_q;
    valid_d    = 1'b0;
    ox_d       = ox_q;
    oy_d       = oy_q;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    lw_d       = lw_q;
    emit       = 1'b0;

    if (cap_valid_q) begin
      // VSYNC restarts the frame from any state, dropping a partial line silently
      if (cap_vs_q) begin
        state_d    = ST_VBLANK;
        x_d        = '0;
        y_d        = '0;
        sof_pend_d = 1'b1;
      end else if (state_q == ST_VBLANK || state_q == ST_HBLANK) begin
        if (cap_de_q) begin
          state_d = ST_ACTIVE;
          emit    = 1'b1;
        end
      end else if (state_q == ST_ACTIVE) begin
        if (cap_de_q) begin
          emit = 1'b1;
        end else begin
          state_d = ST_HBLANK;
          eol_d   = 1'b1;
          lw_d    = x_q;
          x_d     = '0;
          y_d     = (y_q < MAX_H_C) ? y_q + ONE_C : y_q;
        end
      end
    end

    if (emit) begin
      if (x_q < MAX_W_C && y_q < MAX_H_C) begin
        valid_d    = 1'b1;
        gray_d     = luma_sum[15:8];
        ox_d       = x_q;
        oy_d       = y_q;
        sof_d      = sof_pend_q;
        sof_pend_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      x_d = (x_q < MAX_W_C) ? x_q + ONE_C : x_q;
    end
  end

  always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
    if (I_RST) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pclk_prev_q <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_de_q    <= 1'b0;
      cap_vs_q    <= 1'b0;
      cap_hs_q    <= 1'b0;
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sof_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      gray_q      <= '0;
      valid_q     <= 1'b0;
      ox_q        <= '0;
      oy_q        <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      lw_q        <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pclk_prev_q <= pclk_prev_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_de_q    <= cap_de_d;
      cap_vs_q    <= cap_vs_d;
      cap_hs_q    <= cap_hs_d;
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sof_pend_q  <= sof_pend_d;
      err_q       <= err_d;
      gray_q      <= gray_d;
      valid_q     <= valid_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      lw_q        <= lw_d;
    end
  end

  assign O_GRAY       = gray_q;
  assign O_VALID      = valid_q;
  assign O_X          = ox_q;
  assign O_Y          = oy_q;
  assign O_SOF        = sof_q;
  assign O_EOL        = eol_q;
  assign O_LINE_WIDTH = lw_q;
  assign O_ERR        = err_q;

endmodule

`default_nettype wire
